// File: rtl/arbitrated_memory_pkg.sv
// memory_pkg: word/lane geometry and round-robin helper shared by the arbitrated memory.
package memory_pkg;
  localparam int BYTE_LANES = 4;
  localparam int WORD_BITS = 32;
  localparam int BYTE_BITS = 8;
  // Lane 0 is the most significant byte of the word and is enabled by the top wr_en bit.
  function automatic int lane_lsb(input int l);
    return WORD_BITS - BYTE_BITS * (l + 1);
  endfunction
  function automatic int lane_we(input int l);
    return BYTE_LANES - 1 - l;
  endfunction
  function automatic int rr_next(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/arbitrated_memory_if.sv
// arbitrated_memory_if: flattened multi-master request/response bus.
interface arbitrated_memory_if #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_BITS = 17
);
  logic [NUM_MASTERS-1:0] req, lock, gnt, rvalid;
  logic [NUM_MASTERS*ADDR_BITS-1:0] addr;
  logic [NUM_MASTERS*memory_pkg::BYTE_LANES-1:0] wr_en;
  logic [NUM_MASTERS*memory_pkg::WORD_BITS-1:0] wdata;
  logic [memory_pkg::WORD_BITS-1:0] rdata;
  logic addr_err;
  modport master(output req, lock, addr, wr_en, wdata, input gnt, rdata, rvalid, addr_err);
  modport slave(input req, lock, addr, wr_en, wdata, output gnt, rdata, rvalid, addr_err);
endinterface

// File: rtl/arbitrated_memory_mem_bank.sv
// mem_bank: four byte-wide lane arrays, byte-lane writes, registered read-before-write port.
module mem_bank
  import memory_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW = 10
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  zero,
  input  logic [AW-1:0]         addr,
  input  logic [BYTE_LANES-1:0] we,
  input  logic [WORD_BITS-1:0]  wdata,
  output logic [WORD_BITS-1:0]  q
);
  for (genvar l = 0; l < BYTE_LANES; l++) begin : g_lane
    logic [BYTE_BITS-1:0] lane [DEPTH_WORDS];
    logic [BYTE_BITS-1:0] rd;
    always_ff @(posedge clock)
      if (en && we[lane_we(l)]) lane[addr] <= wdata[lane_lsb(l) +: BYTE_BITS];
    always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) rd <= '0;
      else if (en) rd <= zero ? '0 : lane[addr];
    assign q[lane_lsb(l) +: BYTE_BITS] = rd;
  end
endmodule

// File: rtl/arbitrated_memory.sv
// arbitrated_memory: round-robin, lockable multi-master access to a byte-lane word memory.
module arbitrated_memory
  import memory_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int DEPTH_WORDS = 1024,
  parameter int WRAP_ADDR = 1,
  parameter int ADDR_BITS = 17
) (
  input logic clock,
  input logic reset_n,
  arbitrated_memory_if.slave bus
);
  localparam int IW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  logic [IW-1:0] rr_ptr, owner, sel, cand;
  logic locked, any, err;
  logic [ADDR_BITS-1:0] a_sel;
  logic [BYTE_LANES-1:0] we_sel;
  logic [WORD_BITS-1:0] d_sel;
  logic [NUM_MASTERS-1:0] gnt;
  always_comb begin
    sel = '0;
    any = 1'b0;
    cand = rr_ptr;
    if (locked && bus.req[owner]) begin
      sel = owner;
      any = 1'b1;
    end else
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (!any && bus.req[cand]) begin
          sel = cand;
          any = 1'b1;
        end
        cand = IW'(rr_next(int'(cand), NUM_MASTERS));
      end
    any = any && reset_n;
    gnt = '0;
    if (any) gnt[sel] = 1'b1;
  end
  assign bus.gnt = gnt;
  assign a_sel = bus.addr[int'(sel)*ADDR_BITS +: ADDR_BITS];
  assign we_sel = bus.wr_en[int'(sel)*BYTE_LANES +: BYTE_LANES];
  assign d_sel = bus.wdata[int'(sel)*WORD_BITS +: WORD_BITS];
  assign err = (WRAP_ADDR == 0) && (32'(a_sel) >= 32'(DEPTH_WORDS));
  // Out-of-range accesses still pulse rvalid but neither write nor return stored data.
  mem_bank #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_bank (
    .clock  (clock),
    .reset_n(reset_n),
    .en     (any),
    .zero   (err),
    .addr   (a_sel[AW-1:0]),
    .we     (err ? '0 : we_sel),
    .wdata  (d_sel),
    .q      (bus.rdata)
  );
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
      owner <= '0;
      locked <= 1'b0;
      bus.rvalid <= '0;
      bus.addr_err <= 1'b0;
    end else begin
      bus.rvalid <= gnt;
      bus.addr_err <= any && err;
      if (any && NUM_MASTERS > 1 && bus.lock[sel]) begin
        locked <= 1'b1;
        owner <= sel;
      end else if (any) begin
        locked <= 1'b0;
        rr_ptr <= IW'(rr_next(int'(sel), NUM_MASTERS));
      end else if (locked && !bus.req[owner]) locked <= 1'b0;
    end
  end
endmodule

// File: tb/tb_arbitrated_memory.sv
// tb_arbitrated_memory: directed scoreboard bench driving a wrapping and a non-wrapping instance in lockstep.
module tb_arbitrated_memory;
  typedef struct {
    logic [1:0]  v;
    logic [31:0] d;
    logic        k;
    logic        e;
    int          due;
  } exp_t;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] req = '0, lock = '0;
  logic [33:0] addr = '0;
  logic [7:0] wr_en = '0;
  logic [63:0] wdata = '0;
  int checks = 0, failures = 0, cyc = 0;
  exp_t sb[2][$];
  exp_t me;
  logic [1:0] rv[2];
  logic [31:0] rd[2];
  logic er[2];
  arbitrated_memory_if #(.NUM_MASTERS(2), .ADDR_BITS(17)) bw ();
  arbitrated_memory_if #(.NUM_MASTERS(2), .ADDR_BITS(17)) bn ();
  assign bw.req = req;
  assign bw.lock = lock;
  assign bw.addr = addr;
  assign bw.wr_en = wr_en;
  assign bw.wdata = wdata;
  assign bn.req = req;
  assign bn.lock = lock;
  assign bn.addr = addr;
  assign bn.wr_en = wr_en;
  assign bn.wdata = wdata;
  assign rv[0] = bw.rvalid;
  assign rv[1] = bn.rvalid;
  assign rd[0] = bw.rdata;
  assign rd[1] = bn.rdata;
  assign er[0] = bw.addr_err;
  assign er[1] = bn.addr_err;
  arbitrated_memory #(.NUM_MASTERS(2), .DEPTH_WORDS(1024), .WRAP_ADDR(1), .ADDR_BITS(17)) dut_w (
    .clock(clock), .reset_n(reset_n), .bus(bw.slave));
  arbitrated_memory #(.NUM_MASTERS(2), .DEPTH_WORDS(1024), .WRAP_ADDR(0), .ADDR_BITS(17)) dut_n (
    .clock(clock), .reset_n(reset_n), .bus(bn.slave));
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%h required=%h", nm, act, want);
    end
  endtask
  task automatic step(input logic [1:0] r, l, input logic [16:0] a0, a1, input logic [3:0] w0, w1,
                      input logic [31:0] d0, d1, input logic [1:0] g,
                      input logic [31:0] xw, input logic kw, input logic [31:0] xn, input logic kn, xe);
    @(posedge clock);
    #1;
    req = r;
    lock = l;
    addr = {a1, a0};
    wr_en = {w1, w0};
    wdata = {d1, d0};
    #3;
    chk("gnt_wrap", 32'(bw.gnt), 32'(g));
    chk("gnt_nowrap", 32'(bn.gnt), 32'(g));
    if (g != 2'b00) begin
      sb[0].push_back('{g, xw, kw, 1'b0, cyc + 1});
      sb[1].push_back('{g, xn, kn, xe, cyc + 1});
    end
  endtask
  always @(negedge clock) begin
    if (reset_n)
      for (int d = 0; d < 2; d++) begin
        if (sb[d].size() > 0 && sb[d][0].due == cyc) begin
          me = sb[d].pop_front();
          checks++;
          if (rv[d] !== me.v || er[d] !== me.e || (me.k && rd[d] !== me.d)) begin
            failures++;
            $display("FAIL resp_dut%0d cyc=%0d got rvalid=%b rdata=%h err=%b required rvalid=%b rdata=%h(chk=%b) err=%b",
                     d, cyc, rv[d], rd[d], er[d], me.v, me.d, me.k, me.e);
          end
        end else if (rv[d] !== 2'b00) begin
          checks++;
          failures++;
          $display("FAIL spurious_rvalid_dut%0d cyc=%0d got=%b required=00", d, cyc, rv[d]);
        end
      end
  end
  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    req = 2'b11;
    #12;
    chk("rst_gnt_w", 32'(bw.gnt), 32'h0);
    chk("rst_gnt_n", 32'(bn.gnt), 32'h0);
    chk("rst_rvalid_w", 32'(bw.rvalid), 32'h0);
    chk("rst_rvalid_n", 32'(bn.rvalid), 32'h0);
    chk("rst_rdata_w", bw.rdata, 32'h0);
    chk("rst_rdata_n", bn.rdata, 32'h0);
    chk("rst_err_w", 32'(bw.addr_err), 32'h0);
    chk("rst_err_n", 32'(bn.addr_err), 32'h0);
    req = 2'b00;
    #10 reset_n = 1'b1;
    // round-robin with both masters requesting continuously
    step(2'b11, 2'b00, 17'h30, 17'h31, 4'hF, 4'hF, 32'h11111111, 32'h22222222, 2'b01, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(2'b11, 2'b00, 17'h30, 17'h31, 4'hF, 4'hF, 32'h11111111, 32'h22222222, 2'b10, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(2'b11, 2'b00, 17'h30, 17'h31, 4'hF, 4'hF, 32'h11111111, 32'h22222222, 2'b01, 32'h11111111, 1'b1, 32'h11111111, 1'b1, 1'b0);
    step(2'b11, 2'b00, 17'h30, 17'h31, 4'hF, 4'hF, 32'h11111111, 32'h22222222, 2'b10, 32'h22222222, 1'b1, 32'h22222222, 1'b1, 1'b0);
    // full-word write, readback, byte-lane merge
    step(2'b01, 2'b00, 17'h20, 17'h0, 4'hF, 4'h0, 32'hDEADBEEF, 32'h0, 2'b01, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(2'b01, 2'b00, 17'h20, 17'h0, 4'h0, 4'h0, 32'h0, 32'h0, 2'b01, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    step(2'b10, 2'b00, 17'h0, 17'h20, 4'h0, 4'h1, 32'h0, 32'h000000AA, 2'b10, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    step(2'b01, 2'b00, 17'h20, 17'h0, 4'h0, 4'h0, 32'h0, 32'h0, 2'b01, 32'hDEADBEAA, 1'b1, 32'hDEADBEAA, 1'b1, 1'b0);
    // master 1 locks for five cycles, then drops req
    repeat (5)
      step(2'b11, 2'b10, 17'h30, 17'h31, 4'h0, 4'h0, 32'h0, 32'h0, 2'b10, 32'h22222222, 1'b1, 32'h22222222, 1'b1, 1'b0);
    step(2'b01, 2'b00, 17'h30, 17'h31, 4'h0, 4'h0, 32'h0, 32'h0, 2'b01, 32'h11111111, 1'b1, 32'h11111111, 1'b1, 1'b0);
    // owner keeps req but drops lock: one more access, then rotation
    step(2'b11, 2'b10, 17'h30, 17'h31, 4'h0, 4'h0, 32'h0, 32'h0, 2'b10, 32'h22222222, 1'b1, 32'h22222222, 1'b1, 1'b0);
    step(2'b11, 2'b00, 17'h30, 17'h31, 4'h0, 4'h0, 32'h0, 32'h0, 2'b10, 32'h22222222, 1'b1, 32'h22222222, 1'b1, 1'b0);
    step(2'b11, 2'b00, 17'h30, 17'h31, 4'h0, 4'h0, 32'h0, 32'h0, 2'b01, 32'h11111111, 1'b1, 32'h11111111, 1'b1, 1'b0);
    // out-of-range: wrap aliases, no-wrap flags and suppresses
    step(2'b01, 2'b00, 17'h000, 17'h0, 4'hF, 4'h0, 32'h55AA55AA, 32'h0, 2'b01, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(2'b01, 2'b00, 17'h400, 17'h0, 4'hF, 4'h0, 32'hCAFEF00D, 32'h0, 2'b01, 32'h55AA55AA, 1'b1, 32'h0, 1'b1, 1'b1);
    step(2'b01, 2'b00, 17'h000, 17'h0, 4'h0, 4'h0, 32'h0, 32'h0, 2'b01, 32'hCAFEF00D, 1'b1, 32'h55AA55AA, 1'b1, 1'b0);
    step(2'b01, 2'b00, 17'h401, 17'h0, 4'hF, 4'h0, 32'h12345678, 32'h0, 2'b01, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(2'b01, 2'b00, 17'h001, 17'h0, 4'h0, 4'h0, 32'h0, 32'h0, 2'b01, 32'h12345678, 1'b1, 32'h0, 1'b0, 1'b0);
    // reset lands right after an access edge that would raise rvalid and addr_err
    step(2'b01, 2'b00, 17'h400, 17'h0, 4'h0, 4'h0, 32'h0, 32'h0, 2'b01, 32'hCAFEF00D, 1'b1, 32'h0, 1'b1, 1'b1);
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    sb[0].delete();
    sb[1].delete();
    #1;
    chk("midrst_gnt_w", 32'(bw.gnt), 32'h0);
    chk("midrst_gnt_n", 32'(bn.gnt), 32'h0);
    chk("midrst_rvalid_w", 32'(bw.rvalid), 32'h0);
    chk("midrst_rvalid_n", 32'(bn.rvalid), 32'h0);
    chk("midrst_rdata_w", bw.rdata, 32'h0);
    chk("midrst_err_n", 32'(bn.addr_err), 32'h0);
    req = 2'b00;
    #1 reset_n = 1'b1;
    step(2'b11, 2'b00, 17'h30, 17'h31, 4'h0, 4'h0, 32'h0, 32'h0, 2'b01, 32'h11111111, 1'b1, 32'h11111111, 1'b1, 1'b0);
    step(2'b11, 2'b00, 17'h30, 17'h31, 4'h0, 4'h0, 32'h0, 32'h0, 2'b10, 32'h22222222, 1'b1, 32'h22222222, 1'b1, 1'b0);
    repeat (3)
      step(2'b00, 2'b00, 17'h0, 17'h0, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("sb_drained_w", 32'(sb[0].size()), 32'h0);
    chk("sb_drained_n", 32'(sb[1].size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/arbitrated_memory.md
Name: arbitrated_memory

Overview:
- Multi-master, byte-lane-writable word memory. Successor to the single-port test-bench RAM and its ad-hoc CPU/IOP ownership flag.
- Parametrised master count, depth and out-of-range mode. Adds round-robin arbitration, a bus-lock handshake, and a per-master read-valid strobe.
- Sits between the CPU, the IOP (and future DMA masters) and main storage, in simulation and synthesis.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (1..8); index 0 has highest reset priority.
- DEPTH_WORDS, 1024, words of storage; must be a power of two.
- WRAP_ADDR, 1, 1 = address masked to depth; 0 = out-of-range access flagged and suppressed.
- ADDR_BITS, 17, word-address width (bits 15:31 of the Sigma address).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_MASTERS  per-master access request.
- lock  in  NUM_MASTERS  per-master request to keep ownership after the current access.
- addr  in  NUM_MASTERS*ADDR_BITS  flattened word addresses; master i at slice i.
- wr_en  in  NUM_MASTERS*4  flattened byte-lane write enables; lane 0 = data bits 0:7.
- wdata  in  NUM_MASTERS*32  flattened write data.
- gnt  out  NUM_MASTERS  one-hot combinational grant for this cycle.
- rdata  out  32  shared read data, registered.
- rvalid  out  NUM_MASTERS  one-cycle strobe marking rdata as valid for master i.
- addr_err  out  1  registered pulse: the granted access was out of range (WRAP_ADDR=0 only).

Behaviour:
- Reset values: rdata=0, rvalid=0, addr_err=0, owner=none, rr_ptr=0, locked=0. Memory contents are not reset.
- Grant (combinational):
  - If locked and the owner's req=1, the owner is granted.
  - Otherwise grant the first requester found scanning from rr_ptr upward, modulo NUM_MASTERS.
  - No req gives gnt=0. At most one gnt bit is ever set.
- Access: at the rising edge with gnt[i]=1, the access is performed.
  - Read: {lane0..lane3} at the effective address is captured into rdata; rvalid[i]=1 next cycle. Latency is exactly 1.
  - Write: each lane with wr_en=1 is written. rdata returns the pre-write word (read-before-write). rvalid[i] is still pulsed.
- Effective address:
  - WRAP_ADDR=1: addr & (DEPTH_WORDS-1).
  - WRAP_ADDR=0 and addr >= DEPTH_WORDS: no write, rdata=0, addr_err=1 and rvalid[i]=1 in the next cycle.
- Round-robin pointer:
  - After a granted access with lock[i]=0: rr_ptr = i+1 mod NUM_MASTERS, and locked=0.
  - After a granted access with lock[i]=1: locked=1, owner=i, rr_ptr unchanged.
- Lock release:
  - Owner drops req while locked: locked clears in the same edge; arbitration resumes next cycle from rr_ptr.
  - Owner keeps req but drops lock: the current access completes, then normal rotation applies.
- Idle cycles (no req): rvalid=0, addr_err=0, and all arbitration state holds.
- Reset asserted mid-access: outputs clear immediately and the in-flight write is not guaranteed. After release, the first grant goes to the lowest-indexed requester.
- NUM_MASTERS=1: gnt[0]=req[0]; lock has no effect.

Decomposition:
- Shared package memory_pkg holds:
  - BYTE_LANES=4, WORD_BITS=32, BYTE_BITS=8;
  - the lane-to-bit-range mapping;
  - a function for the round-robin next index.
- One sub-module, mem_bank: four byte-wide arrays of DEPTH_WORDS, one read port and byte-lane writes, synchronous read. It keeps $readmemh preload capability through a hierarchical temp array.
- The arbiter and lock logic stay in the top module.

Test Plan:
- Single master 0 writes 0xDEADBEEF to word 0x20 with wr_en=1111, then reads it → rvalid[0] one cycle after the read grant, rdata=0xDEADBEEF.
- Master 1 writes 0x000000AA to 0x20 with wr_en=0001, master 0 then reads 0x20 → rdata=0xDEADBEAA.
- Both masters hold req=1 continuously after reset, lock=0 → gnt alternates 01,10,01,10; each rvalid tracks the prior cycle's grant.
- Master 1 wins with lock=1, master 0 requesting → master 1 granted for 5 consecutive cycles. Master 1 drops req → master 0 granted the following cycle.
- WRAP_ADDR=0, DEPTH_WORDS=1024, write to 0x400 → addr_err=1 next cycle, rdata=0; word 0x000 is unchanged on readback.
- WRAP_ADDR=1, write 0x12345678 to 0x401 → readback of 0x001 returns 0x12345678.
- reset_n pulsed low mid-burst → gnt, rvalid and addr_err are 0 within the same cycle; after release, master 0 is granted first.
